calc_core: RTL and testbench

- Arithmetic core directly downstream of the parameter loader.
- Consumes signed operands a0/a1 and the level-type start_calc request; returns core_busy as the back-pressure/handshake signal.
- Computes the signed 64-bit product a0*a1 with an iterative shift-add multiplier (one bit per cycle), reports completion with a one-cycle result_valid pulse, and drives an 8-bit output pin view of the result.

---
 rtl/calc_if.sv | 38 +++
 rtl/calc_core.sv | 178 +++++++++++++++++
 tb/tb_calc_core.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/calc_if.sv
// Handshake/operand bundle between the parameter loader and calc_core.
// The loader side uses the master modport; the arithmetic core uses the slave modport.
interface calc_if #(
  parameter int WIDTH = 32
) ();

  logic signed [WIDTH-1:0]   a0;
  logic signed [WIDTH-1:0]   a1;
  logic                      start_calc;
  logic                      core_busy;
  logic signed [2*WIDTH-1:0] result;
  logic                      result_valid;
  logic [7:0]                out_pins;
  logic                      overflow;

  modport master (
    output a0,
    output a1,
    output start_calc,
    input  core_busy,
    input  result,
    input  result_valid,
    input  out_pins,
    input  overflow
  );

  modport slave (
    input  a0,
    input  a1,
    input  start_calc,
    output core_busy,
    output result,
    output result_valid,
    output out_pins,
    output overflow
  );

endinterface

// File: rtl/calc_core.sv
// Signed WIDTH x WIDTH iterative shift-add multiplier with a constant WIDTH+2 cycle latency.
// Build option CALC_CORE_SAT_EN: out_pins saturates to signed 8 bits instead of wrapping.
module calc_core #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  calc_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

`ifdef CALC_CORE_SAT_EN
  // Returns {clamped, pin_byte}: in range when every bit above bit 7 copies the sign.
  function automatic logic [8:0] sat_clamp(input logic [PW-1:0] r);
    if ((r[PW-1:7] == {(PW-7){1'b0}}) || (r[PW-1:7] == {(PW-7){1'b1}})) begin
      sat_clamp = {1'b0, r[7:0]};
    end else if (r[PW-1]) begin
      sat_clamp = {1'b1, 8'h80};
    end else begin
      sat_clamp = {1'b1, 8'h7F};
    end
  endfunction
`endif

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             start_q_r;
  logic             accept_s;
  logic             busy_r;
  logic             neg_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [PW-1:0]    acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    acc_sum_s;
  logic [PW-1:0]    final_s;
  logic [8:0]       pin_s;
  logic [PW-1:0]    result_r;
  logic             result_valid_r;
  logic [7:0]       out_pins_r;
  logic             overflow_r;

  assign accept_s = (state_r == ST_IDLE) && bus.start_calc && !start_q_r;

  // Next-state selection for the IDLE/LOAD/MUL/DONE sequencer.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: state_next_s = ST_MUL;
      ST_MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Partial-product add, and the signed result including the final iteration's term.
  always_comb begin
    acc_sum_s = acc_r;
    final_s   = {PW{1'b0}};
    pin_s     = 9'd0;
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
    if (neg_r) begin
      final_s = ~acc_sum_s + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      final_s = acc_sum_s;
    end
`ifdef CALC_CORE_SAT_EN
    pin_s = sat_clamp(final_s);
`else
    pin_s = {1'b0, final_s[7:0]};
`endif
  end

  // Sequencer state, start edge history and the busy flag derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      start_q_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      start_q_r <= bus.start_calc;
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  // Datapath: operand capture, shift-add iterations, and the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_r          <= 1'b0;
      mcand_r        <= {PW{1'b0}};
      mplier_r       <= {WIDTH{1'b0}};
      acc_r          <= {PW{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      result_r       <= {PW{1'b0}};
      result_valid_r <= 1'b0;
      out_pins_r     <= 8'h00;
      overflow_r     <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(bus.a0)};
            mplier_r <= magnitude(bus.a1);
            neg_r    <= bus.a0[WIDTH-1] ^ bus.a1[WIDTH-1];
          end
        end
        ST_LOAD: begin
          acc_r <= {PW{1'b0}};
          cnt_r <= {CNT_W{1'b0}};
        end
        ST_MUL: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          // Register the result on the last iteration so it is visible in DONE.
          if (cnt_r == CNT_LAST) begin
            result_r       <= final_s;
            out_pins_r     <= pin_s[7:0];
            overflow_r     <= pin_s[8];
            result_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= {PW{1'b0}};
        end
      endcase
    end
  end

  assign bus.core_busy    = busy_r;
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.out_pins     = out_pins_r;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed corner cases plus randomized operands
// compared against a plain-arithmetic signed product model.
module tb_calc_core;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  calc_if #(.WIDTH(W)) bus ();

  calc_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model(input int x, input int y, output longint p,
                       output logic [7:0] pins, output logic ov);
    p = longint'(x) * longint'(y);
`ifdef CALC_CORE_SAT_EN
    if (p > 64'sd127) begin
      pins = 8'h7F;
      ov   = 1'b1;
    end else if (p < -64'sd128) begin
      pins = 8'h80;
      ov   = 1'b1;
    end else begin
      pins = p[7:0];
      ov   = 1'b0;
    end
`else
    pins = p[7:0];
    ov   = 1'b0;
`endif
  endtask

  task automatic run_op(input int x, input int y, input string tag);
    longint     p;
    logic [7:0] pins;
    logic       ov;
    int         n;
    model(x, y, p, pins, ov);
    bus.a0 = x;
    bus.a1 = y;
    bus.start_calc = 1'b1;
    tick();
    check({tag, "_busy_t1"}, 64'(bus.core_busy), 64'd1);
    bus.a0 = $urandom;
    bus.a1 = $urandom;
    bus.start_calc = 1'b0;
    n = 1;
    while (bus.result_valid !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_result"}, bus.result, p);
    check({tag, "_pins"}, 64'(bus.out_pins), 64'(pins));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(ov));
    check({tag, "_busy_done"}, 64'(bus.core_busy), 64'd1);
    tick();
    check({tag, "_valid_off"}, 64'(bus.result_valid), 64'd0);
    check({tag, "_busy_idle"}, 64'(bus.core_busy), 64'd0);
  endtask

  initial begin
    int pulses;
    int rx;
    int ry;
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    bus.a0 = '0;
    bus.a1 = '0;
    bus.start_calc = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(bus.core_busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_valid", 64'(bus.result_valid), 64'd0);
    check("rst_pins", 64'(bus.out_pins), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(3, 5, "p3x5");
    run_op(-7, 6, "m7x6");
    run_op(32'sh8000_0000, 32'sh8000_0000, "minxmin");
    run_op(1000, 1000, "k1xk1");
    run_op(0, -5, "zero");
    run_op(-1, -1, "m1xm1");
    run_op(-100, 2, "m100x2");
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        rx = $urandom;
        ry = $urandom;
      end else begin
        rx = int'($urandom_range(0, 40)) - 20;
        ry = int'($urandom_range(0, 40)) - 20;
      end
      run_op(rx, ry, $sformatf("rnd%0d", i));
    end

    // Level held high for 100 cycles must trigger exactly once.
    bus.a0 = 9;
    bus.a1 = -3;
    bus.start_calc = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_result", bus.result, 64'(-64'sd27));
    bus.start_calc = 1'b0;
    tick();
    tick();

    // Re-raise during MUL is ignored and never replayed.
    bus.a0 = 11;
    bus.a1 = 12;
    bus.start_calc = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i == 5) bus.start_calc = 1'b0;
      if (i == 7) bus.start_calc = 1'b1;
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("retrig_pulses", 64'(pulses), 64'd1);
    check("retrig_result", bus.result, 64'd132);
    check("retrig_busy", 64'(bus.core_busy), 64'd0);
    bus.start_calc = 1'b0;
    tick();

    // Reset in the middle of a calculation.
    bus.a0 = 77;
    bus.a1 = 3;
    bus.start_calc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_busy", 64'(bus.core_busy), 64'd1);
    rst_n = 1'b0;
    bus.start_calc = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(bus.core_busy), 64'd0);
    check("midrst_result", bus.result, 64'd0);
    check("midrst_pins", 64'(bus.out_pins), 64'd0);
    check("midrst_valid", 64'(bus.result_valid), 64'd0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);
    run_op(-12, 12, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
